// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
// Bundle of the request-side and memory-write-side signals of instr_encoder.
//
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2); sizes the occupancy signal
//   ADDR_W - width of the instruction byte address
//
// Signals:
//   in_valid / in_ready          request handshake
//   in_op, in_rd, in_rn, in_rm,  request fields
//   in_imm
//   addr_clear                   zero the output address counter
//   out_valid / out_ready        memory-write handshake
//   out_word, out_addr           encoded word and its byte address
//   count                        FIFO occupancy
//   err                          sticky illegal-op flag
//
// Modports:
//   master - the request producer / memory consumer (testbench, loader)
//   slave  - the encoder itself
// -----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [18:0]       in_imm;
  logic              addr_clear;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_word;
  logic [ADDR_W-1:0] out_addr;
  logic [CNT_W-1:0]  count;
  logic              err;

  modport master (
    output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, addr_clear, out_ready,
    input  in_ready, out_valid, out_word, out_addr, count, err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rn, in_rm, in_imm, addr_clear, out_ready,
    output in_ready, out_valid, out_word, out_addr, count, err
  );
endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Streaming LEGv8 instruction encoder for the program-load path. Field-level
// requests (ADD, SUB, AND, ORR, LDUR, STUR, CBZ) are encoded into 32-bit
// machine words, buffered in a DEPTH-entry FIFO and presented to the
// instruction-memory write port with an auto-incrementing byte address.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-high
//   bus    - instr_encoder_if.slave (request handshake + fields, memory-write
//            handshake, word/address, occupancy, error flag)
//
// Parameters:
//   DEPTH  - FIFO entries (power of two, >= 2)
//   ADDR_W - width of the instruction byte address (wraps modulo 2^ADDR_W)
//
// Build option:
//   INSTR_ENCODER_CHECK_EN - when defined, op 7 is accepted but dropped and
//   sets the sticky err flag; when undefined, op 7 encodes as 32'h00000000
//   and err is tied low.
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  instr_encoder_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_ORR  = 3'd3;
  localparam logic [2:0] OP_LDUR = 3'd4;
  localparam logic [2:0] OP_STUR = 3'd5;
  localparam logic [2:0] OP_CBZ  = 3'd6;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rn,
    input logic [4:0]  rm,
    input logic [18:0] imm
  );
    logic [31:0] w;
    case (op)
      OP_ADD:  w = {11'h458, rm, 6'd0, rn, rd};
      OP_SUB:  w = {11'h658, rm, 6'd0, rn, rd};
      OP_AND:  w = {11'h450, rm, 6'd0, rn, rd};
      OP_ORR:  w = {11'h550, rm, 6'd0, rn, rd};
      OP_LDUR: w = {11'h7C2, imm[8:0], 2'b00, rn, rd};
      OP_STUR: w = {11'h7C0, imm[8:0], 2'b00, rn, rd};
      OP_CBZ:  w = {8'hB4, imm, rd};
      default: w = 32'h0000_0000;  // illegal op: decoder default, all controls off
    endcase
    return w;
  endfunction

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic full, empty;
  logic push_acc;   // input handshake completes
  logic write_en;   // word actually stored in the FIFO
  logic pop;
  logic is_illegal;

  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    is_illegal = (bus.in_op == 3'd7);
    // Fullness is judged before any same-cycle pop: no bypass.
    push_acc   = bus.in_valid && !full;
    pop        = !empty && bus.out_ready;
`ifdef INSTR_ENCODER_CHECK_EN
    write_en   = push_acc && !is_illegal;
`else
    write_en   = push_acc;
`endif

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;

    if (write_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({write_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Clear wins over the post-transfer increment.
    if (bus.addr_clear) addr_d = '0;
    else if (pop)       addr_d = addr_q + ADDR_W'(4);
  end

  // Control state: pointers, occupancy, address.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

  // FIFO storage carries no reset; stale entries are never visible because
  // out_word is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && write_en)
      mem_q[wr_ptr_q] <= encode(bus.in_op, bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (push_acc && is_illegal);
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.out_word  = empty ? 32'h0000_0000 : mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign bus.count     = count_q;
endmodule
